sp_mem_responder: RTL and testbench
===================================

# sp_mem_responder

Responder end of the single-port block-memory port (clka/ena/wea/addra/dina/douta) driven by the team's test initiators and processor-side masters. It provides word storage with per-byte write enables, a configurable read pipeline, and a `douta_valid` strobe so initiators need not count latency. It also zero-scrubs its array after every reset, signalling `busy` until the array is clean. It replaces the vendor memory behind the design wrapper wherever a synthesizable, verifiable model is needed.

## Interface
- `DEPTH`, 1024: number of 32-bit words; power of two, ≥ 16.
- `LATENCY`, 1: read latency in cycles; legal values 1 or 2.
- `WRITE_MODE`, READ_FIRST: `douta` content on a write access; READ_FIRST or WRITE_FIRST.
- `SCRUB_EN`, 1: when 1, the array is zeroed after reset; when 0, there is no scrub.
- `clka` in 1: the only clock; all logic is on the rising edge.
- `rsta_n` in 1: synchronous, active-low reset.
- `ena` in 1: access request, sampled each cycle.
- `wea` in 4: byte write enables; bit i writes `dina[8i+7:8i]`. All zeros means read.
- `addra` in 32: byte address. Word index is `addra[AW+1:2]`, where AW = clog2(DEPTH). `addra[1:0]` is ignored.
- `dina` in 32: write data.
- `douta` out 32: response data.
- `douta_valid` out 1: one-cycle strobe marking a response on `douta`.
- `addr_err` out 1: asserted with `douta_valid` when the response's address was out of range.
- `busy` out 1: high during reset and scrub; accesses are ignored while high.

## Operation
- States: SCRUB, READY.
  - With `rsta_n`=0, the block enters SCRUB, or READY if SCRUB_EN=0.
  - SCRUB → READY after the write to index DEPTH-1.
- SCRUB:
  - A counter writes 0 to index 0..DEPTH-1, one word per cycle, starting the first cycle with `rsta_n`=1.
  - `ena` is ignored; no responses are produced.
- Accepted access: `ena`=1 and state READY.
  - Exactly one response follows every accepted access, reads and writes alike.
- Out of range: `addra` ≥ 4·DEPTH.
  - No array write occurs.
  - Response data is 0 with `addr_err`=1.
- Write, `wea`≠0:
  - Only the enabled byte lanes are updated.
  - READ_FIRST: response data is the word before the write.
  - WRITE_FIRST: response data is the merged new word.
- Read, `wea`=0: response data is the stored word.
- Back-to-back accesses are legal every cycle. Responses keep request order with one response per cycle.
- Reset has no effect on array contents. Only the scrub clears them.
- `douta` holds its last response value between responses; it is not zeroed when idle.

## Timing
- Reset values: `douta`=0, `douta_valid`=0, `addr_err`=0, `busy`=1 (`busy`=0 if SCRUB_EN=0). The pipeline is flushed and the scrub counter is set to 0.
- After `rsta_n` rises, `busy` stays high for exactly DEPTH cycles. It is low on the edge after the index DEPTH-1 write.
- LATENCY=1: an access sampled at edge N gives `douta`/`douta_valid`/`addr_err` valid after edge N+1.
- LATENCY=2: the same response appears one edge later, at N+2.
- Write followed by a read of the same address on the next cycle: the read returns the new data (no hazard).
- Reset asserted mid-scrub: the scrub restarts from index 0.
- Reset asserted with responses in flight: the responses are dropped and `douta_valid` is 0 the cycle after.
- `ena` asserted on the cycle `busy` falls (first READY cycle) is accepted.

## Structure
- Package `sp_mem_pkg`:
  - `write_mode_e` {READ_FIRST, WRITE_FIRST}.
  - `state_e` {SCRUB, READY}.
  - Data width 32 and byte-lane count 4 as constants.
- Sub-module `sp_mem_array`: the DEPTH×32 storage with a single port and byte enables, registered read (read-first raw output).
- Top level holds the FSM, scrub counter/mux, range check, write-mode merge, and LATENCY pipeline for data/valid/err.

## Test plan
- Reset and scrub, DEPTH=16: hold `rsta_n`=0 for 10 cycles, then release. Required: `busy`=1 for exactly 16 cycles. After that, reads of indices 0..15 return 0x00000000 with `addr_err`=0.
- Full write/read, LATENCY=1: write `addra`=0, `wea`=F, `dina`=0x5555555D. Next cycle read `addra`=0. Required: read response 0x5555555D one cycle after the read.
- Byte lanes, WRITE_MODE=WRITE_FIRST: word 4 (`addra`=0x10) holds 0x5555555D. Write `wea`=4'b0101, `dina`=0xAABBCCDD. Required: write response 0x55BB55DD; a subsequent read also returns 0x55BB55DD. Repeat with READ_FIRST: write response 0x5555555D.
- Streaming, LATENCY=2: read `addra`=0, 4, 8, 12 on consecutive cycles. Required: four consecutive `douta_valid` pulses starting 2 cycles after the first, with data in request order.
- Out of range, DEPTH=16: read `addra`=0x40. Required: `douta`=0 with `addr_err`=1. Then write `addra`=0x40 followed by a read of `addra`=0. Required: the read returns the index-0 value, unchanged by the out-of-range write.
- Reset mid-operation: pull `rsta_n` low at scrub index 7, or with 2 reads in flight. Required: scrub restarts (`busy` high for a further DEPTH cycles); no `douta_valid` pulse after reset.

Source files
------------

// File: rtl/sp_mem_pkg.sv
// sp_mem_pkg: shared types and constants for the single-port memory responder.
//   write_mode_e : what douta shows for a write access (old word or merged word)
//   state_e      : responder FSM states
//   DATA_W       : word width in bits
//   NUM_BYTES    : byte lanes per word
//   merge_bytes  : byte-lane merge of new data into an old word
package sp_mem_pkg;

    typedef enum logic {
        READ_FIRST  = 1'b0,
        WRITE_FIRST = 1'b1
    } write_mode_e;

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_e;

    localparam int DATA_W    = 32;
    localparam int NUM_BYTES = 4;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0]    old_word,
        input logic [DATA_W-1:0]    new_word,
        input logic [NUM_BYTES-1:0] be
    );
        logic [DATA_W-1:0] r;
        r = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sp_mem_array.sv
// sp_mem_array: DEPTH x 32 single-port storage with byte write enables.
// The read is registered and read-first: rdata shows the word as it was
// before any write performed on the same edge.
//   clk   : clock, rising edge
//   en    : port enable; nothing happens (rdata holds) when low
//   we    : byte write enables, bit i writes wdata[8i+7:8i]
//   addr  : word index
//   wdata : write data
//   rdata : registered read data (pre-write contents)
module sp_mem_array
    import sp_mem_pkg::*;
#(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [NUM_BYTES-1:0]     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/sp_mem_responder.sv
// sp_mem_responder: responder end of a single-port block-memory port.
// Word storage with byte enables, LATENCY-cycle read pipeline, a response
// strobe, out-of-range flagging and a zero-scrub of the array after reset.
//   clka        : clock, rising edge
//   rsta_n      : synchronous active-low reset
//   ena         : access request
//   wea         : byte write enables (0 = read)
//   addra       : byte address; word index is addra[AW+1:2]
//   dina        : write data
//   douta       : response data, held between responses
//   douta_valid : one-cycle response strobe
//   addr_err    : response was for an out-of-range address
//   busy        : reset/scrub in progress, accesses ignored
//   fsm_state   : current FSM state (0 = SCRUB, 1 = READY)
//
// Handshake: there is no backpressure. A request is accepted on any rising
// edge where ena=1 and the FSM is READY; exactly one response follows it,
// LATENCY edges later, marked by a single-cycle douta_valid. Responses are
// delivered in request order, at most one per cycle.
module sp_mem_responder
    import sp_mem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          LATENCY    = 1,
    parameter write_mode_e WRITE_MODE = READ_FIRST,
    parameter bit          SCRUB_EN   = 1'b1
) (
    input  logic        clka,
    input  logic        rsta_n,
    input  logic        ena,
    input  logic [3:0]  wea,
    input  logic [31:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta,
    output logic        douta_valid,
    output logic        addr_err,
    output logic        busy,
    output logic        fsm_state
);

    localparam int AW = $clog2(DEPTH);

    state_e          state;
    logic [AW-1:0]   scrub_idx;

    logic            scrubbing;
    logic            in_range;
    logic            acc;
    logic            unused_addr_lsbs;

    logic            arr_en;
    logic [3:0]      arr_we;
    logic [AW-1:0]   arr_addr;
    logic [31:0]     arr_wdata;
    logic [31:0]     rd_data;

    // Stage 0: request attributes aligned with the array's registered read
    logic            s0_v;
    logic            s0_err;
    logic [3:0]      s0_wea;
    logic [31:0]     s0_din;
    logic [31:0]     resp_data;

    // Values presented to the output register (after optional extra stage)
    logic            o_v;
    logic            o_err;
    logic [31:0]     o_data;

    // Byte offset within a word never affects the access
    assign unused_addr_lsbs = &{1'b0, addra[1:0]};

    assign scrubbing = rsta_n && (state == SCRUB);
    assign in_range  = ((addra >> (AW + 2)) == 32'd0);
    assign acc       = rsta_n && ena && (state == READY);

    assign busy      = (state == SCRUB);
    assign fsm_state = (state == READY);

    // FSM and scrub counter. Scrub writes index 0 on the first edge with
    // rsta_n=1 and leaves SCRUB on the edge that writes index DEPTH-1.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            state     <= SCRUB_EN ? SCRUB : READY;
            scrub_idx <= '0;
        end else if (state == SCRUB) begin
            scrub_idx <= scrub_idx + AW'(1);
            if (scrub_idx == AW'(DEPTH - 1)) state <= READY;
        end
    end

    // Port mux: scrub owns the array while active; out-of-range accesses
    // never enable it, so they cannot corrupt storage.
    assign arr_en    = scrubbing || (acc && in_range);
    assign arr_we    = scrubbing ? 4'hF : wea;
    assign arr_addr  = scrubbing ? scrub_idx : addra[AW+1:2];
    assign arr_wdata = scrubbing ? 32'h0 : dina;

    sp_mem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clka),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (rd_data)
    );

    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            s0_v   <= 1'b0;
            s0_err <= 1'b0;
            s0_wea <= '0;
            s0_din <= '0;
        end else begin
            s0_v   <= acc;
            s0_err <= !in_range;
            s0_wea <= wea;
            s0_din <= dina;
        end
    end

    // rd_data is stale for out-of-range requests; the error masks it.
    always_comb begin
        resp_data = rd_data;
        if (s0_err) begin
            resp_data = 32'h0;
        end else if ((WRITE_MODE == WRITE_FIRST) && (s0_wea != 4'h0)) begin
            resp_data = merge_bytes(rd_data, s0_din, s0_wea);
        end
    end

    generate
        if (LATENCY == 2) begin : g_lat2
            logic        p_v;
            logic        p_err;
            logic [31:0] p_data;

            always_ff @(posedge clka) begin
                if (!rsta_n) begin
                    p_v    <= 1'b0;
                    p_err  <= 1'b0;
                    p_data <= '0;
                end else begin
                    p_v    <= s0_v;
                    p_err  <= s0_err;
                    p_data <= resp_data;
                end
            end

            assign o_v    = p_v;
            assign o_err  = p_err;
            assign o_data = p_data;
        end else begin : g_lat1
            assign o_v    = s0_v;
            assign o_err  = s0_err;
            assign o_data = resp_data;
        end
    endgenerate

    // douta only loads on a response so it holds the last value when idle.
    always_ff @(posedge clka) begin
        if (!rsta_n) begin
            douta       <= '0;
            douta_valid <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            douta_valid <= o_v;
            addr_err    <= o_v && o_err;
            if (o_v) douta <= o_data;
        end
    end

endmodule

// File: tb/tb_sp_mem_responder.sv
// tb_sp_mem_responder: drives two responders (DEPTH=16) from one stimulus
// stream: dut_a is LATENCY=1/READ_FIRST, dut_b is LATENCY=2/WRITE_FIRST.
// Each request pushes the hand-computed response (data, err, due cycle) into
// a per-DUT expected queue; per-DUT monitors pop and compare on douta_valid.
module tb_sp_mem_responder;
    import sp_mem_pkg::*;

    localparam int DEPTH = 16;
    localparam int LAT_A = 1;
    localparam int LAT_B = 2;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rsta_n;
    logic        ena;
    logic [3:0]  wea;
    logic [31:0] addra;
    logic [31:0] dina;

    logic [31:0] douta_a, douta_b;
    logic        valid_a, valid_b;
    logic        err_a, err_b;
    logic        busy_a, busy_b;
    logic        state_a, state_b;

    sp_mem_responder #(
        .DEPTH(DEPTH), .LATENCY(LAT_A), .WRITE_MODE(READ_FIRST), .SCRUB_EN(1'b1)
    ) dut_a (
        .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .douta(douta_a), .douta_valid(valid_a), .addr_err(err_a),
        .busy(busy_a), .fsm_state(state_a)
    );

    sp_mem_responder #(
        .DEPTH(DEPTH), .LATENCY(LAT_B), .WRITE_MODE(WRITE_FIRST), .SCRUB_EN(1'b1)
    ) dut_b (
        .clka(clk), .rsta_n(rsta_n), .ena(ena), .wea(wea), .addra(addra),
        .dina(dina), .douta(douta_b), .douta_valid(valid_b), .addr_err(err_b),
        .busy(busy_b), .fsm_state(state_b)
    );

    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [31:0] due;
    } exp_t;

    exp_t exp_a_q[$];
    exp_t exp_b_q[$];
    exp_t ea, eb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (valid_a) begin
            if (exp_a_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected: got douta_valid=1 data 0x%08h expected no response (cycle %0d)", douta_a, cyc);
            end else begin
                ea = exp_a_q.pop_front();
                chk("a_data", douta_a, ea.data);
                chk("a_err", {31'b0, err_a}, {31'b0, ea.err});
                chk("a_cycle", cyc, ea.due);
            end
        end
    end

    always @(negedge clk) begin
        if (valid_b) begin
            if (exp_b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected: got douta_valid=1 data 0x%08h expected no response (cycle %0d)", douta_b, cyc);
            end else begin
                eb = exp_b_q.pop_front();
                chk("b_data", douta_b, eb.data);
                chk("b_err", {31'b0, err_b}, {31'b0, eb.err});
                chk("b_cycle", cyc, eb.due);
            end
        end
    end

    // Driver: called at a negedge, returns at the next negedge.
    task automatic access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d,
                          input logic [31:0] exp_rf, input logic [31:0] exp_wf, input logic err,
                          input bit push_a = 1'b1, input bit push_b = 1'b1);
        exp_t e;
        ena   = 1'b1;
        wea   = w;
        addra = a;
        dina  = d;
        if (push_a) begin
            e.data = exp_rf; e.err = err; e.due = cyc + 32'(1 + LAT_A);
            exp_a_q.push_back(e);
        end
        if (push_b) begin
            e.data = exp_wf; e.err = err; e.due = cyc + 32'(1 + LAT_B);
            exp_b_q.push_back(e);
        end
        @(negedge clk);
        ena = 1'b0;
        wea = 4'h0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp_d);
        access(a, 4'h0, 32'h0, exp_d, exp_d, 1'b0);
    endtask

    // Called at the negedge where rsta_n was raised; returns on the first
    // negedge with both busy low. Records the edge count to busy low per DUT.
    task automatic wait_scrub(input string name);
        int n  = 0;
        int fa = 0;
        int fb = 0;
        while ((fa == 0 || fb == 0) && n < 200) begin
            @(negedge clk);
            n++;
            if (!busy_a && fa == 0) fa = n;
            if (!busy_b && fb == 0) fb = n;
        end
        chk({name, "_a"}, 32'(fa), 32'(DEPTH));
        chk({name, "_b"}, 32'(fb), 32'(DEPTH));
    endtask

    task automatic drain_and_check_empty(input string name);
        repeat (5) @(negedge clk);
        chk({name, "_qa_empty"}, 32'(exp_a_q.size()), 32'd0);
        chk({name, "_qb_empty"}, 32'(exp_b_q.size()), 32'd0);
    endtask

    initial begin
        rsta_n = 1'b0;
        ena    = 1'b0;
        wea    = 4'h0;
        addra  = 32'h0;
        dina   = 32'h0;
        repeat (10) @(negedge clk);

        // Reset values
        chk("rst_douta_a", douta_a, 32'h0);
        chk("rst_valid_a", {31'b0, valid_a}, 32'h0);
        chk("rst_err_a",   {31'b0, err_a},   32'h0);
        chk("rst_busy_a",  {31'b0, busy_a},  32'h1);
        chk("rst_douta_b", douta_b, 32'h0);
        chk("rst_valid_b", {31'b0, valid_b}, 32'h0);
        chk("rst_busy_b",  {31'b0, busy_b},  32'h1);

        // Scrub length, then reads start on the first READY cycle
        rsta_n = 1'b1;
        wait_scrub("scrub_len");
        chk("ready_state_a", {31'b0, state_a}, 32'h1);
        for (int i = 0; i < DEPTH; i++) rd(32'(4 * i), 32'h0);

        // Full write, then read of the same word on the next cycle
        access(32'h0, 4'hF, 32'h5555555D, 32'h0, 32'h5555555D, 1'b0);
        rd(32'h0, 32'h5555555D);

        // Byte lanes on word 4
        access(32'h10, 4'hF, 32'h5555555D, 32'h0, 32'h5555555D, 1'b0);
        access(32'h10, 4'b0101, 32'hAABBCCDD, 32'h5555555D, 32'h55BB55DD, 1'b0);
        rd(32'h10, 32'h55BB55DD);

        // Streaming: writes then back-to-back reads
        access(32'h4, 4'hF, 32'h11111111, 32'h0, 32'h11111111, 1'b0);
        access(32'h8, 4'hF, 32'h22222222, 32'h0, 32'h22222222, 1'b0);
        access(32'hC, 4'hF, 32'h33333333, 32'h0, 32'h33333333, 1'b0);
        rd(32'h0, 32'h5555555D);
        rd(32'h4, 32'h11111111);
        rd(32'h8, 32'h22222222);
        rd(32'hC, 32'h33333333);

        // Out of range
        access(32'h40, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        access(32'h40, 4'hF, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1);
        rd(32'h0, 32'h5555555D);
        access(32'hFFFFFFFC, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Last word, with ignored byte offset
        access(32'h3E, 4'hF, 32'h12345678, 32'h0, 32'h12345678, 1'b0);
        rd(32'h3C, 32'h12345678);
        rd(32'h3F, 32'h12345678);
        drain_and_check_empty("main");

        // Reset with reads in flight: only dut_a's first read escapes
        access(32'h0, 4'h0, 32'h0, 32'h5555555D, 32'h5555555D, 1'b0, 1'b1, 1'b0);
        access(32'h4, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        rsta_n = 1'b0;
        @(negedge clk);
        chk("inflight_valid_a", {31'b0, valid_a}, 32'h0);
        chk("inflight_valid_b", {31'b0, valid_b}, 32'h0);
        chk("inflight_busy_a",  {31'b0, busy_a},  32'h1);
        repeat (3) @(negedge clk);
        chk("inflight_valid_b_late", {31'b0, valid_b}, 32'h0);

        // Reset mid-scrub at index 7, with ena asserted (must be ignored)
        rsta_n = 1'b1;
        ena    = 1'b1;
        wea    = 4'hF;
        addra  = 32'h0;
        dina   = 32'hFFFFFFFF;
        repeat (7) @(negedge clk);
        chk("midscrub_busy_a", {31'b0, busy_a}, 32'h1);
        ena    = 1'b0;
        wea    = 4'h0;
        rsta_n = 1'b0;
        repeat (2) @(negedge clk);
        rsta_n = 1'b1;
        wait_scrub("rescrub_len");

        // Every word, including previously written ones, is zero again
        for (int i = 0; i < DEPTH; i++) rd(32'(4 * i), 32'h0);
        drain_and_check_empty("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
